decode_exec_writeback: RTL and testbench

Integer decode, execute and write-back slice of the five-stage DLX pipeline; it sits between the IFU (IF/ID outputs) and the memory unit. It holds the 32×32 register file, decodes instructions, and resolves branches and jumps in decode. It owns the ID/EX and EX/MEM pipeline registers and the ALU with forwarding muxes. It also performs the write-back mux from MEM/WB inputs. The external hazard unit supplies the forwarding selects.

---
 rtl/decode_exec_writeback.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_decode_exec_writeback.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_writeback.sv
`default_nettype none
// ============================================================================
// Module   : decode_exec_writeback
// Purpose  : Integer decode / execute / write-back slice of a five-stage DLX
//            pipeline. Holds the 32x32 register file, decodes the IF/ID
//            instruction, resolves branches and jumps in decode, owns the
//            ID/EX and EX/MEM registers, the ALU with forwarding muxes and
//            the MEM/WB write-back mux.
// Ports    : clk_i, rst_ni                - clock, async active-low reset
//            instruction_i, pc_plus4_i    - IF/ID stage inputs
//            fwd_a_i, fwd_b_i, mem_aluout_i - forwarding selects and data
//            wb_*_i                       - MEM/WB stage inputs
//            rs1_o, rs2_o, branch_o, jump_o, jump_reg_o, branch_target_o,
//            bus_a_o                      - decode-stage outputs
//            ex_*_o                       - EX/MEM register outputs
//            bus_w_o, wrenable_o, rw_w_o  - write-back port
// Revision : 1.0 - initial release
// ============================================================================
module decode_exec_writeback (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instruction_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [1:0]  fwd_a_i,
    input  logic [1:0]  fwd_b_i,
    input  logic [31:0] mem_aluout_i,
    input  logic        wb_mem2reg_i,
    input  logic        wb_regwrite_i,
    input  logic        wb_jal_i,
    input  logic [4:0]  wb_rw_i,
    input  logic [31:0] wb_dmemout_i,
    input  logic [31:0] wb_aluout_i,
    input  logic [31:0] wb_link_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        jump_reg_o,
    output logic [31:0] branch_target_o,
    output logic [31:0] bus_a_o,
    output logic        ex_memwrite_o,
    output logic        ex_mem2reg_o,
    output logic        ex_regwrite_o,
    output logic        ex_loadext_o,
    output logic        ex_jal_o,
    output logic [1:0]  ex_dsize_o,
    output logic [4:0]  ex_rw_o,
    output logic [31:0] ex_aluout_o,
    output logic [31:0] ex_busb_o,
    output logic [31:0] ex_link_o,
    output logic [31:0] bus_w_o,
    output logic        wrenable_o,
    output logic [4:0]  rw_w_o
);

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SEQ  = 4'd8;
    localparam logic [3:0] c_ALU_SNE  = 4'd9;
    localparam logic [3:0] c_ALU_SLT  = 4'd10;
    localparam logic [3:0] c_ALU_SGT  = 4'd11;
    localparam logic [3:0] c_ALU_SLE  = 4'd12;
    localparam logic [3:0] c_ALU_SGE  = 4'd13;
    localparam logic [3:0] c_ALU_PASB = 4'd14;

    typedef struct packed {
        logic       memwrite;
        logic       mem2reg;
        logic       regwrite;
        logic       loadext;
        logic       jal;
        logic [1:0] dsize;
        logic [4:0] rw;
    } ctrl_t;

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] bus_w;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [31:0] regs_q [32];

    assign opcode = instruction_i[31:26];
    assign func   = instruction_i[5:0];
    assign rs1_o  = instruction_i[25:21];
    assign rs2_o  = instruction_i[20:16];

    // ---------------- write-back ----------------
    assign bus_w      = wb_jal_i ? wb_link_i : (wb_mem2reg_i ? wb_dmemout_i : wb_aluout_i);
    assign bus_w_o    = bus_w;
    assign wrenable_o = wb_regwrite_i;
    assign rw_w_o     = wb_rw_i;

    // ---------------- register file ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_regwrite_i && (wb_rw_i != 5'd0)) begin
            regs_q[wb_rw_i] <= bus_w;
        end
    end

    // Write-first bypass so a decode in the write-back cycle sees the new value.
    assign rdata_a = (rs1_o == 5'd0) ? 32'd0 :
                     (wb_regwrite_i && (wb_rw_i == rs1_o)) ? bus_w : regs_q[rs1_o];
    assign rdata_b = (rs2_o == 5'd0) ? 32'd0 :
                     (wb_regwrite_i && (wb_rw_i == rs2_o)) ? bus_w : regs_q[rs2_o];
    assign bus_a_o = rdata_a;

    // ---------------- branch / jump resolution ----------------
    logic        is_jimm;
    logic [31:0] sext16;
    logic [31:0] sext26;

    assign is_jimm         = (opcode == 6'd2) || (opcode == 6'd3);
    assign sext16          = {{16{instruction_i[15]}}, instruction_i[15:0]};
    assign sext26          = {{6{instruction_i[25]}}, instruction_i[25:0]};
    assign branch_target_o = pc_plus4_i + (is_jimm ? sext26 : sext16);
    assign branch_o        = ((opcode == 6'd4) && (rdata_a == 32'd0)) ||
                             ((opcode == 6'd5) && (rdata_a != 32'd0));
    assign jump_o          = is_jimm || (opcode == 6'd18) || (opcode == 6'd19);
    assign jump_reg_o      = (opcode == 6'd18) || (opcode == 6'd19);

    // ---------------- decode ----------------
    ctrl_t       dec_ctrl;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_aluop;
    logic        dec_use_imm;
    logic        dec_zext;
    logic        dec_lhi;
    logic [31:0] dec_imm;

    always_comb begin
        dec_ctrl    = '0;
        dec_rd      = instruction_i[20:16];
        dec_aluop   = c_ALU_ADD;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b0;
        dec_lhi     = 1'b0;
        case (opcode)
            6'd0: begin
                dec_use_imm       = 1'b0;
                dec_rd            = instruction_i[15:11];
                dec_ctrl.regwrite = 1'b1;
                case (func)
                    6'h20, 6'h21: dec_aluop = c_ALU_ADD;
                    6'h22, 6'h23: dec_aluop = c_ALU_SUB;
                    6'h24: dec_aluop = c_ALU_AND;
                    6'h25: dec_aluop = c_ALU_OR;
                    6'h26: dec_aluop = c_ALU_XOR;
                    6'h04: dec_aluop = c_ALU_SLL;
                    6'h06: dec_aluop = c_ALU_SRL;
                    6'h07: dec_aluop = c_ALU_SRA;
                    6'h28: dec_aluop = c_ALU_SEQ;
                    6'h29: dec_aluop = c_ALU_SNE;
                    6'h2A: dec_aluop = c_ALU_SLT;
                    6'h2B: dec_aluop = c_ALU_SGT;
                    6'h2C: dec_aluop = c_ALU_SLE;
                    6'h2D: dec_aluop = c_ALU_SGE;
                    default: dec_ctrl.regwrite = 1'b0;
                endcase
            end
            6'd8, 6'd9:   begin dec_aluop = c_ALU_ADD; dec_ctrl.regwrite = 1'b1; end
            6'd10, 6'd11: begin dec_aluop = c_ALU_SUB; dec_ctrl.regwrite = 1'b1; end
            6'd12: begin dec_aluop = c_ALU_AND; dec_zext = 1'b1; dec_ctrl.regwrite = 1'b1; end
            6'd13: begin dec_aluop = c_ALU_OR;  dec_zext = 1'b1; dec_ctrl.regwrite = 1'b1; end
            6'd14: begin dec_aluop = c_ALU_XOR; dec_zext = 1'b1; dec_ctrl.regwrite = 1'b1; end
            6'd15: begin dec_aluop = c_ALU_PASB; dec_lhi = 1'b1; dec_ctrl.regwrite = 1'b1; end
            6'd20: begin dec_aluop = c_ALU_SLL; dec_ctrl.regwrite = 1'b1; end
            6'd22: begin dec_aluop = c_ALU_SRL; dec_ctrl.regwrite = 1'b1; end
            6'd23: begin dec_aluop = c_ALU_SRA; dec_ctrl.regwrite = 1'b1; end
            6'd24: begin dec_aluop = c_ALU_SEQ; dec_ctrl.regwrite = 1'b1; end
            6'd25: begin dec_aluop = c_ALU_SNE; dec_ctrl.regwrite = 1'b1; end
            6'd26: begin dec_aluop = c_ALU_SLT; dec_ctrl.regwrite = 1'b1; end
            6'd27: begin dec_aluop = c_ALU_SGT; dec_ctrl.regwrite = 1'b1; end
            6'd28: begin dec_aluop = c_ALU_SLE; dec_ctrl.regwrite = 1'b1; end
            6'd29: begin dec_aluop = c_ALU_SGE; dec_ctrl.regwrite = 1'b1; end
            6'd32, 6'd33, 6'd35, 6'd36, 6'd37: begin
                dec_ctrl.mem2reg  = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.loadext  = (opcode == 6'd32) || (opcode == 6'd33);
                dec_ctrl.dsize    = (opcode == 6'd35) ? 2'b10 :
                                    ((opcode == 6'd33) || (opcode == 6'd37)) ? 2'b01 : 2'b00;
            end
            6'd40, 6'd41, 6'd43: begin
                dec_ctrl.memwrite = 1'b1;
                dec_ctrl.dsize    = (opcode == 6'd43) ? 2'b10 :
                                    (opcode == 6'd41) ? 2'b01 : 2'b00;
            end
            6'd3, 6'd19: begin
                dec_ctrl.jal      = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_rd            = 5'd31;
            end
            default: ;
        endcase
        // Non-writing instructions carry rw=0 so EX/MEM looks like a bubble.
        dec_ctrl.rw = dec_ctrl.regwrite ? dec_rd : 5'd0;
    end

    assign dec_imm = dec_lhi  ? {instruction_i[15:0], 16'h0000} :
                     dec_zext ? {16'h0000, instruction_i[15:0]} : sext16;

    // ---------------- ID/EX register ----------------
    ctrl_t       idex_ctrl_q;
    logic [3:0]  idex_aluop_q;
    logic        idex_use_imm_q;
    logic [31:0] idex_a_q;
    logic [31:0] idex_b_q;
    logic [31:0] idex_imm_q;
    logic [31:0] idex_link_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idex_ctrl_q    <= '0;
            idex_aluop_q   <= c_ALU_ADD;
            idex_use_imm_q <= 1'b0;
            idex_a_q       <= '0;
            idex_b_q       <= '0;
            idex_imm_q     <= '0;
            idex_link_q    <= '0;
        end else begin
            idex_ctrl_q    <= dec_ctrl;
            idex_aluop_q   <= dec_aluop;
            idex_use_imm_q <= dec_use_imm;
            idex_a_q       <= rdata_a;
            idex_b_q       <= rdata_b;
            idex_imm_q     <= dec_imm;
            idex_link_q    <= pc_plus4_i + 32'd4;
        end
    end

    // ---------------- execute ----------------
    logic [31:0] ex_a;
    logic [31:0] ex_rt;
    logic [31:0] ex_b;
    logic [31:0] alu_res;

    always_comb begin
        case (fwd_a_i)
            2'b01:   ex_a = mem_aluout_i;
            2'b10:   ex_a = bus_w;
            default: ex_a = idex_a_q;
        endcase
        case (fwd_b_i)
            2'b01:   ex_rt = mem_aluout_i;
            2'b10:   ex_rt = bus_w;
            default: ex_rt = idex_b_q;
        endcase
    end

    assign ex_b = idex_use_imm_q ? idex_imm_q : ex_rt;

    always_comb begin
        alu_res = '0;
        case (idex_aluop_q)
            c_ALU_ADD:  alu_res = ex_a + ex_b;
            c_ALU_SUB:  alu_res = ex_a - ex_b;
            c_ALU_AND:  alu_res = ex_a & ex_b;
            c_ALU_OR:   alu_res = ex_a | ex_b;
            c_ALU_XOR:  alu_res = ex_a ^ ex_b;
            c_ALU_SLL:  alu_res = ex_a << ex_b[4:0];
            c_ALU_SRL:  alu_res = ex_a >> ex_b[4:0];
            c_ALU_SRA:  alu_res = $unsigned($signed(ex_a) >>> ex_b[4:0]);
            c_ALU_SEQ:  alu_res = {31'd0, ex_a == ex_b};
            c_ALU_SNE:  alu_res = {31'd0, ex_a != ex_b};
            c_ALU_SLT:  alu_res = {31'd0, $signed(ex_a) <  $signed(ex_b)};
            c_ALU_SGT:  alu_res = {31'd0, $signed(ex_a) >  $signed(ex_b)};
            c_ALU_SLE:  alu_res = {31'd0, $signed(ex_a) <= $signed(ex_b)};
            c_ALU_SGE:  alu_res = {31'd0, $signed(ex_a) >= $signed(ex_b)};
            c_ALU_PASB: alu_res = ex_b;
            default:    alu_res = '0;
        endcase
    end

    // ---------------- EX/MEM register ----------------
    ctrl_t       exmem_ctrl_q;
    logic [31:0] exmem_aluout_q;
    logic [31:0] exmem_busb_q;
    logic [31:0] exmem_link_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exmem_ctrl_q   <= '0;
            exmem_aluout_q <= '0;
            exmem_busb_q   <= '0;
            exmem_link_q   <= '0;
        end else begin
            exmem_ctrl_q   <= idex_ctrl_q;
            exmem_aluout_q <= alu_res;
            exmem_busb_q   <= ex_rt;
            exmem_link_q   <= idex_link_q;
        end
    end

    assign ex_memwrite_o = exmem_ctrl_q.memwrite;
    assign ex_mem2reg_o  = exmem_ctrl_q.mem2reg;
    assign ex_regwrite_o = exmem_ctrl_q.regwrite;
    assign ex_loadext_o  = exmem_ctrl_q.loadext;
    assign ex_jal_o      = exmem_ctrl_q.jal;
    assign ex_dsize_o    = exmem_ctrl_q.dsize;
    assign ex_rw_o       = exmem_ctrl_q.rw;
    assign ex_aluout_o   = exmem_aluout_q;
    assign ex_busb_o     = exmem_busb_q;
    assign ex_link_o     = exmem_link_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_exec_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_exec_writeback
// Purpose  : Self-checking bench for decode_exec_writeback: decode table,
//            directed multi-cycle sequences and a randomized run against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_exec_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, pc4, mem_aluout, wb_dmemout, wb_aluout, wb_link;
    logic [1:0]  fwd_a, fwd_b;
    logic        wb_mem2reg, wb_regwrite, wb_jal;
    logic [4:0]  wb_rw;
    logic [4:0]  rs1, rs2, ex_rw, rw_w;
    logic        branch, jump, jump_reg, wrenable;
    logic        ex_memwrite, ex_mem2reg, ex_regwrite, ex_loadext, ex_jal;
    logic [1:0]  ex_dsize;
    logic [31:0] branch_target, bus_a, ex_aluout, ex_busb, ex_link, bus_w;

    decode_exec_writeback dut (
        .clk_i(clk), .rst_ni(rst_n), .instruction_i(instr), .pc_plus4_i(pc4),
        .fwd_a_i(fwd_a), .fwd_b_i(fwd_b), .mem_aluout_i(mem_aluout),
        .wb_mem2reg_i(wb_mem2reg), .wb_regwrite_i(wb_regwrite), .wb_jal_i(wb_jal),
        .wb_rw_i(wb_rw), .wb_dmemout_i(wb_dmemout), .wb_aluout_i(wb_aluout),
        .wb_link_i(wb_link), .rs1_o(rs1), .rs2_o(rs2), .branch_o(branch),
        .jump_o(jump), .jump_reg_o(jump_reg), .branch_target_o(branch_target),
        .bus_a_o(bus_a), .ex_memwrite_o(ex_memwrite), .ex_mem2reg_o(ex_mem2reg),
        .ex_regwrite_o(ex_regwrite), .ex_loadext_o(ex_loadext), .ex_jal_o(ex_jal),
        .ex_dsize_o(ex_dsize), .ex_rw_o(ex_rw), .ex_aluout_o(ex_aluout),
        .ex_busb_o(ex_busb), .ex_link_o(ex_link), .bus_w_o(bus_w),
        .wrenable_o(wrenable), .rw_w_o(rw_w)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr = '0; pc4 = '0; fwd_a = '0; fwd_b = '0; mem_aluout = '0;
        wb_mem2reg = 1'b0; wb_regwrite = 1'b0; wb_jal = 1'b0; wb_rw = '0;
        wb_dmemout = '0; wb_aluout = '0; wb_link = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_regwrite = 1'b1; wb_rw = r; wb_aluout = d; wb_jal = 1'b0; wb_mem2reg = 1'b0;
        tick();
        wb_regwrite = 1'b0; wb_rw = '0; wb_aluout = '0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        memwrite, mem2reg, regwrite, loadext, jal, chk_alu;
        logic [1:0]  dsize;
        logic [4:0]  rw;
        logic [31:0] aluout, busb, link;
    } exp_t;

    logic [31:0] mregs [32];
    logic [31:0] m_ins, m_a, m_rt, m_pc4;
    exp_t        m_ex;

    function automatic exp_t exp_zero();
        exp_t e;
        e.memwrite = 0; e.mem2reg = 0; e.regwrite = 0; e.loadext = 0; e.jal = 0;
        e.chk_alu = 0; e.dsize = 0; e.rw = 0; e.aluout = 0; e.busb = 0; e.link = 0;
        return e;
    endfunction

    // {valid, result} for an R-type function code
    function automatic logic [32:0] ref_alu(input logic [5:0] fn, input logic [31:0] a, b);
        int sa, sb;
        int sh;
        logic [31:0] r;
        sa = $signed(a); sb = $signed(b); sh = int'(b % 32);
        r = 0;
        case (fn)
            6'h20, 6'h21: r = a + b;
            6'h22, 6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h04: r = a << sh;
            6'h06: r = a >> sh;
            6'h07: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            6'h28: r = (a == b)  ? 32'd1 : 32'd0;
            6'h29: r = (a != b)  ? 32'd1 : 32'd0;
            6'h2A: r = (sa < sb)  ? 32'd1 : 32'd0;
            6'h2B: r = (sa > sb)  ? 32'd1 : 32'd0;
            6'h2C: r = (sa <= sb) ? 32'd1 : 32'd0;
            6'h2D: r = (sa >= sb) ? 32'd1 : 32'd0;
            default: return {1'b0, 32'd0};
        endcase
        return {1'b1, r};
    endfunction

    function automatic logic [5:0] itype_func(input logic [5:0] op);
        case (op)
            6'd8: return 6'h20;  6'd9: return 6'h21;  6'd10: return 6'h22;
            6'd11: return 6'h23; 6'd12: return 6'h24; 6'd13: return 6'h25;
            6'd14: return 6'h26; 6'd20: return 6'h04; 6'd22: return 6'h06;
            6'd23: return 6'h07;
            6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29: return 6'h28 + (op - 6'd24);
            default: return 6'h3F;
        endcase
    endfunction

    function automatic exp_t model_exec(input logic [31:0] ins, a, rt, p4);
        exp_t e;
        logic [5:0]  op;
        logic [31:0] sx, zx;
        logic [32:0] res;
        e = exp_zero();
        op = ins[31:26];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        e.link = p4 + 32'd4;
        e.busb = rt;
        if (op == 6'd0) begin
            res = ref_alu(ins[5:0], a, rt);
            if (res[32]) begin
                e.regwrite = 1; e.rw = ins[15:11]; e.aluout = res[31:0]; e.chk_alu = 1;
            end
        end else if (itype_func(op) != 6'h3F) begin
            res = ref_alu(itype_func(op), a, (op >= 6'd12 && op <= 6'd14) ? zx : sx);
            e.regwrite = 1; e.rw = ins[20:16]; e.aluout = res[31:0]; e.chk_alu = 1;
        end else if (op == 6'd15) begin
            e.regwrite = 1; e.rw = ins[20:16]; e.aluout = {ins[15:0], 16'h0}; e.chk_alu = 1;
        end else if (op == 6'd32 || op == 6'd33 || op == 6'd35 || op == 6'd36 || op == 6'd37) begin
            e.mem2reg = 1; e.regwrite = 1; e.rw = ins[20:16]; e.aluout = a + sx; e.chk_alu = 1;
            e.loadext = (op == 6'd32 || op == 6'd33);
            e.dsize = (op == 6'd35) ? 2 : (op == 6'd33 || op == 6'd37) ? 1 : 0;
        end else if (op == 6'd40 || op == 6'd41 || op == 6'd43) begin
            e.memwrite = 1; e.aluout = a + sx; e.chk_alu = 1;
            e.dsize = (op == 6'd43) ? 2 : (op == 6'd41) ? 1 : 0;
        end else if (op == 6'd3 || op == 6'd19) begin
            e.jal = 1; e.regwrite = 1; e.rw = 5'd31;
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic [31:0] bw);
        if (r == 0) return 32'd0;
        if (wb_regwrite && wb_rw == r) return bw;
        return mregs[r];
    endfunction

    task automatic check_ex(input string tag, input exp_t e);
        check({tag, "_ctrl"}, {25'd0, ex_memwrite, ex_mem2reg, ex_regwrite, ex_loadext, ex_jal, ex_dsize},
              {25'd0, e.memwrite, e.mem2reg, e.regwrite, e.loadext, e.jal, e.dsize});
        check({tag, "_rw"}, {27'd0, ex_rw}, {27'd0, e.rw});
        check({tag, "_busb"}, ex_busb, e.busb);
        if (e.chk_alu) check({tag, "_aluout"}, ex_aluout, e.aluout);
        if (e.jal)     check({tag, "_link"}, ex_link, e.link);
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] p4;
        logic        br, jmp, jr;
        logic [31:0] tgt;
    } dvec_t;

    dvec_t tbl [8];

    int vops [35] = '{0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 18, 19, 20, 22, 23,
                      24, 25, 26, 27, 28, 29, 32, 33, 35, 36, 37, 40, 41, 43};
    int vfn  [16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h04, 'h06, 'h07,
                      'h28, 'h29, 'h2A, 'h2B, 'h2C, 'h2D};

    initial begin
        logic [31:0] bw, ra, rb, fa, fb, ins;
        logic [5:0]  op;

        tbl[0] = '{itype(6'd4, 5'd0, 5'd0, 16'd16),     32'h40,   1'b1, 1'b0, 1'b0, 32'h50};
        tbl[1] = '{itype(6'd5, 5'd0, 5'd0, 16'd16),     32'h40,   1'b0, 1'b0, 1'b0, 32'h50};
        tbl[2] = '{itype(6'd4, 5'd0, 5'd0, 16'hFFFC),   32'h100,  1'b1, 1'b0, 1'b0, 32'hFC};
        tbl[3] = '{{6'd2, 26'h3FF_FFF8},                32'h1000, 1'b0, 1'b1, 1'b0, 32'hFF8};
        tbl[4] = '{{6'd3, 26'h000_0020},                32'h200,  1'b0, 1'b1, 1'b0, 32'h220};
        tbl[5] = '{itype(6'd18, 5'd0, 5'd0, 16'd0),     32'h300,  1'b0, 1'b1, 1'b1, 32'h300};
        tbl[6] = '{itype(6'd8, 5'd0, 5'd1, 16'd5),      32'h10,   1'b0, 1'b0, 1'b0, 32'h15};
        tbl[7] = '{itype(6'd19, 5'd0, 5'd0, 16'd0),     32'h0,    1'b0, 1'b1, 1'b1, 32'h0};

        do_reset();

        // reset state of the EX/MEM outputs
        check("rst_ex_ctrl", {25'd0, ex_memwrite, ex_mem2reg, ex_regwrite, ex_loadext, ex_jal, ex_dsize}, 32'd0);
        check("rst_ex_aluout", ex_aluout, 32'd0);

        for (int i = 0; i < 8; i++) begin
            instr = tbl[i].ins; pc4 = tbl[i].p4;
            #1;
            check($sformatf("tbl%0d_branch", i), {31'd0, branch}, {31'd0, tbl[i].br});
            check($sformatf("tbl%0d_jump", i), {31'd0, jump}, {31'd0, tbl[i].jmp});
            check($sformatf("tbl%0d_jump_reg", i), {31'd0, jump_reg}, {31'd0, tbl[i].jr});
            check($sformatf("tbl%0d_target", i), branch_target, tbl[i].tgt);
        end
        clear_inputs();

        wb_write(5'd1, 32'h100);
        wb_write(5'd6, 32'hFFFF_FFFF);
        wb_write(5'd7, 32'h1);

        // same-cycle write-first read of r3
        instr = itype(6'd8, 5'd3, 5'd0, 16'd0);
        wb_regwrite = 1'b1; wb_rw = 5'd3; wb_aluout = 32'h1234;
        #1;
        check("wfirst_bus_a", bus_a, 32'h1234);
        tick();
        wb_regwrite = 1'b0; wb_rw = '0; wb_aluout = '0;
        #1;
        check("r3_stored", bus_a, 32'h1234);

        // writes to r0 are dropped
        instr = itype(6'd8, 5'd0, 5'd0, 16'd0);
        wb_regwrite = 1'b1; wb_rw = 5'd0; wb_aluout = 32'hFFFF;
        #1;
        check("r0_same_cycle", bus_a, 32'd0);
        tick();
        wb_regwrite = 1'b0; wb_aluout = '0;
        #1;
        check("r0_after_write", bus_a, 32'd0);

        // write-back mux priority
        wb_jal = 1'b1; wb_mem2reg = 1'b1; wb_link = 32'hAAAA_0000; wb_dmemout = 32'h11; wb_aluout = 32'h22;
        #1; check("busw_link", bus_w, 32'hAAAA_0000);
        wb_jal = 1'b0;
        #1; check("busw_dmem", bus_w, 32'h11);
        wb_mem2reg = 1'b0;
        #1; check("busw_alu", bus_w, 32'h22);
        clear_inputs();

        // LB r4,8(r1)
        instr = itype(6'd32, 5'd1, 5'd4, 16'd8);
        tick(); instr = '0; tick();
        check("lb_aluout", ex_aluout, 32'h108);
        check("lb_ctrl", {25'd0, ex_memwrite, ex_mem2reg, ex_regwrite, ex_loadext, ex_jal, ex_dsize},
              {25'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00});
        check("lb_rw", {27'd0, ex_rw}, 32'd4);

        // SLT r5,r6,r7 with r6=-1, r7=1
        instr = rtype(5'd6, 5'd7, 5'd5, 6'h2A);
        tick(); instr = '0; tick();
        check("slt_aluout", ex_aluout, 32'd1);
        check("slt_rw", {27'd0, ex_rw}, 32'd5);

        // JAL from pc_plus4=0x200
        instr = {6'd3, 26'h20}; pc4 = 32'h200;
        #1;
        check("jal_jump", {31'd0, jump}, 32'd1);
        check("jal_target", branch_target, 32'h220);
        tick(); instr = '0; pc4 = '0; tick();
        check("jal_rw", {27'd0, ex_rw}, 32'd31);
        check("jal_link", ex_link, 32'h204);
        check("jal_flags", {30'd0, ex_jal, ex_regwrite}, 32'd3);

        // ADDI r1,r0,5 ; ADD r2,r1,r1 with operands forwarded from MEM
        instr = itype(6'd8, 5'd0, 5'd1, 16'd5);
        tick();
        instr = rtype(5'd1, 5'd1, 5'd2, 6'h20);
        tick();
        instr = '0; fwd_a = 2'b01; fwd_b = 2'b01; mem_aluout = 32'd5;
        #1;
        check("addi_aluout", ex_aluout, 32'd5);
        check("addi_rw", {27'd0, ex_rw}, 32'd1);
        tick();
        fwd_a = '0; fwd_b = '0; mem_aluout = '0;
        check("add_fwd_aluout", ex_aluout, 32'd10);
        check("add_rw", {27'd0, ex_rw}, 32'd2);
        check("add_regwrite", {31'd0, ex_regwrite}, 32'd1);

        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("arst_ex_ctrl", {25'd0, ex_memwrite, ex_mem2reg, ex_regwrite, ex_loadext, ex_jal, ex_dsize}, 32'd0);
        check("arst_ex_rw", {27'd0, ex_rw}, 32'd0);
        check("arst_ex_aluout", ex_aluout, 32'd0);
        check("arst_ex_busb", ex_busb, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++) begin
            instr = itype(6'd8, 5'(r), 5'd0, 16'd0);
            #1;
            check($sformatf("arst_r%0d", r), bus_a, 32'd0);
        end

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        m_ins = '0; m_a = '0; m_rt = '0; m_pc4 = '0;
        m_ex = exp_zero();

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            ins = $urandom;
            if ($urandom_range(15) == 0) op = 6'($urandom);
            else op = 6'(vops[$urandom_range(34)]);
            ins[31:26] = op;
            if ($urandom_range(1) == 1) ins[25:21] = 5'($urandom_range(7));
            if ($urandom_range(1) == 1) ins[20:16] = 5'($urandom_range(7));
            if (op == 6'd0 && $urandom_range(7) != 0) ins[5:0] = 6'(vfn[$urandom_range(15)]);
            instr = ins;
            pc4 = $urandom & 32'hFFFF_FFFC;
            fwd_a = 2'($urandom); fwd_b = 2'($urandom);
            mem_aluout = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
            wb_regwrite = 1'($urandom); wb_mem2reg = 1'($urandom); wb_jal = 1'($urandom_range(3) == 0);
            wb_rw = 5'($urandom); wb_dmemout = $urandom; wb_link = $urandom;
            wb_aluout = ($urandom_range(3) == 0) ? 32'd0 : $urandom;

            @(negedge clk);
            bw = wb_jal ? wb_link : (wb_mem2reg ? wb_dmemout : wb_aluout);
            ra = ref_read(ins[25:21], bw);
            rb = ref_read(ins[20:16], bw);
            check("rnd_rs", {22'd0, rs1, rs2}, {22'd0, ins[25:21], ins[20:16]});
            check("rnd_bus_a", bus_a, ra);
            check("rnd_branch", {31'd0, branch},
                  {31'd0, (op == 6'd4 && ra == 0) || (op == 6'd5 && ra != 0)});
            check("rnd_jump", {30'd0, jump, jump_reg},
                  {30'd0, (op == 6'd2 || op == 6'd3 || op == 6'd18 || op == 6'd19), (op == 6'd18 || op == 6'd19)});
            check("rnd_target", branch_target,
                  (op == 6'd2 || op == 6'd3) ? pc4 + {{6{ins[25]}}, ins[25:0]} : pc4 + {{16{ins[15]}}, ins[15:0]});
            check("rnd_bus_w", bus_w, bw);
            check("rnd_wb_port", {26'd0, wrenable, rw_w}, {26'd0, wb_regwrite, wb_rw});
            check_ex("rnd_ex", m_ex);

            fa = (fwd_a == 2'b01) ? mem_aluout : (fwd_a == 2'b10) ? bw : m_a;
            fb = (fwd_b == 2'b01) ? mem_aluout : (fwd_b == 2'b10) ? bw : m_rt;
            m_ex  = model_exec(m_ins, fa, fb, m_pc4);
            m_ins = ins; m_a = ra; m_rt = rb; m_pc4 = pc4;
            if (wb_regwrite && wb_rw != 0) mregs[wb_rw] = bw;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
